// File: rtl/systolic_tile_ctrl_if.sv
// Bus bundle between the tile sequencer and its memories / systolic array.
//   wb_mem_*  : weight buffer read port (cenb active low, wenb tied high)
//   ib_mem_*  : input buffer read port  (cenb active low, wenb tied high)
//   w_load_o  : array strobe, weight word valid on the weight memory data bus
//   i_valid_o : array strobe, input word valid on the input memory data bus
//   res_*     : result row coming back from the array
//   ob_mem_*  : output buffer write port (cenb/wenb active low)
// master = sequencer side, slave = memory/array side.
interface systolic_tile_ctrl_if #(
    parameter int WIDTH  = 8,
    parameter int COL    = 4,
    parameter int W_SIZE = 256,
    parameter int I_SIZE = 256,
    parameter int O_SIZE = 256
);
    logic                        wb_mem_cenb_o;
    logic                        wb_mem_wenb_o;
    logic [$clog2(W_SIZE)-1:0]   wb_mem_addr_o;
    logic                        ib_mem_cenb_o;
    logic                        ib_mem_wenb_o;
    logic [$clog2(I_SIZE)-1:0]   ib_mem_addr_o;
    logic                        w_load_o;
    logic                        i_valid_o;
    logic                        res_valid_i;
    logic [COL*WIDTH-1:0]        res_data_i;
    logic                        ob_mem_cenb_o;
    logic                        ob_mem_wenb_o;
    logic [$clog2(O_SIZE)-1:0]   ob_mem_addr_o;
    logic [COL*WIDTH-1:0]        ob_mem_data_o;

    modport master (
        output wb_mem_cenb_o, wb_mem_wenb_o, wb_mem_addr_o,
        output ib_mem_cenb_o, ib_mem_wenb_o, ib_mem_addr_o,
        output w_load_o, i_valid_o,
        input  res_valid_i, res_data_i,
        output ob_mem_cenb_o, ob_mem_wenb_o, ob_mem_addr_o, ob_mem_data_o
    );

    modport slave (
        input  wb_mem_cenb_o, wb_mem_wenb_o, wb_mem_addr_o,
        input  ib_mem_cenb_o, ib_mem_wenb_o, ib_mem_addr_o,
        input  w_load_o, i_valid_o,
        output res_valid_i, res_data_i,
        input  ob_mem_cenb_o, ob_mem_wenb_o, ob_mem_addr_o, ob_mem_data_o
    );
endinterface

// File: rtl/systolic_tile_ctrl.sv
// Sequencer for one matrix_mult tile pass.
// On a rising edge of start_i: preload ROW weight words into the array,
// stream num_vec input words, write each returned result row to the output
// buffer, then raise done_o until start_i drops.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i               level, pass begins on its rising edge
//   w/i/o_base_i          first word address in each buffer
//   num_vec_i             number of input vectors (0..I_SIZE)
//   busy_o / done_o       pass in progress / pass complete
//   ovf_o                 sticky, a result arrived that had no slot
//   bus                   memory and array ports (master side)
module systolic_tile_ctrl #(
    parameter int WIDTH  = 8,
    parameter int ROW    = 4,
    parameter int COL    = 4,
    parameter int W_SIZE = 256,
    parameter int I_SIZE = 256,
    parameter int O_SIZE = 256
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic [$clog2(W_SIZE)-1:0]  w_base_i,
    input  logic [$clog2(I_SIZE)-1:0]  i_base_i,
    input  logic [$clog2(O_SIZE)-1:0]  o_base_i,
    input  logic [$clog2(I_SIZE):0]    num_vec_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       ovf_o,
    systolic_tile_ctrl_if.master       bus
);
    localparam int WA = $clog2(W_SIZE);
    localparam int IA = $clog2(I_SIZE);
    localparam int OA = $clog2(O_SIZE);
    localparam int CW = $clog2(I_SIZE) + 1;
    localparam int DW = COL * WIDTH;

    typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;

    state_t           state_reg, state_next;
    logic             start_prev_reg;
    logic [IA-1:0]    i_base_reg, i_base_next;
    logic [OA-1:0]    o_base_reg, o_base_next;
    logic [CW-1:0]    num_vec_reg, num_vec_next;
    logic [CW-1:0]    cnt_reg, cnt_next;       // k in LOAD_W, n in STREAM
    logic [CW-1:0]    wcnt_reg, wcnt_next;     // result rows written so far
    logic             wb_cenb_reg, wb_cenb_next;
    logic [WA-1:0]    wb_addr_reg, wb_addr_next;
    logic             ib_cenb_reg, ib_cenb_next;
    logic [IA-1:0]    ib_addr_reg, ib_addr_next;
    logic             ob_cenb_reg, ob_cenb_next;
    logic [OA-1:0]    ob_addr_reg, ob_addr_next;
    logic [DW-1:0]    ob_data_reg, ob_data_next;
    logic             ovf_reg, ovf_next;
    logic             busy_reg, done_reg, w_load_reg, i_valid_reg;

    logic             start_edge;
    logic             in_pass;
    logic [CW:0]      ob_sum;

    assign start_edge = start_i & ~start_prev_reg;
    assign in_pass    = (state_reg == LOAD_W) || (state_reg == STREAM) || (state_reg == DRAIN);
    // Wide enough that o_base + wcnt never overflows before the modulo.
    assign ob_sum     = (CW+1)'(o_base_reg) + (CW+1)'(wcnt_reg);

    always_comb begin
        state_next   = state_reg;
        i_base_next  = i_base_reg;
        o_base_next  = o_base_reg;
        num_vec_next = num_vec_reg;
        cnt_next     = cnt_reg;
        wcnt_next    = wcnt_reg;
        wb_cenb_next = wb_cenb_reg;
        wb_addr_next = wb_addr_reg;
        ib_cenb_next = ib_cenb_reg;
        ib_addr_next = ib_addr_reg;
        ob_cenb_next = 1'b1;
        ob_addr_next = ob_addr_reg;
        ob_data_next = ob_data_reg;
        ovf_next     = ovf_reg;

        // Result capture runs alongside the read sequencing; a row with no
        // remaining slot (or outside a pass) only sets the sticky overflow.
        if (bus.res_valid_i) begin
            if (in_pass && (wcnt_reg < num_vec_reg)) begin
                ob_cenb_next = 1'b0;
                ob_addr_next = OA'(ob_sum % O_SIZE);
                ob_data_next = bus.res_data_i;
                wcnt_next    = wcnt_reg + 1'b1;
            end else begin
                ovf_next = 1'b1;
            end
        end

        unique case (state_reg)
            IDLE: begin
                // Placed after the result logic so a fresh start clears ovf.
                if (start_edge) begin
                    i_base_next  = i_base_i;
                    o_base_next  = o_base_i;
                    num_vec_next = num_vec_i;
                    wcnt_next    = '0;
                    ovf_next     = 1'b0;
                    cnt_next     = '0;
                    if (num_vec_i == '0) begin
                        state_next = DONE;
                    end else begin
                        state_next   = LOAD_W;
                        wb_cenb_next = 1'b0;
                        wb_addr_next = w_base_i;
                    end
                end
            end
            LOAD_W: begin
                if (cnt_reg == CW'(ROW - 1)) begin
                    state_next   = STREAM;
                    cnt_next     = '0;
                    wb_cenb_next = 1'b1;
                    ib_cenb_next = 1'b0;
                    ib_addr_next = i_base_reg;
                end else begin
                    cnt_next     = cnt_reg + 1'b1;
                    wb_addr_next = (wb_addr_reg == WA'(W_SIZE - 1)) ? '0 : wb_addr_reg + 1'b1;
                end
            end
            STREAM: begin
                if (cnt_reg == num_vec_reg - 1'b1) begin
                    state_next   = DRAIN;
                    ib_cenb_next = 1'b1;
                end else begin
                    cnt_next     = cnt_reg + 1'b1;
                    ib_addr_next = (ib_addr_reg == IA'(I_SIZE - 1)) ? '0 : ib_addr_reg + 1'b1;
                end
            end
            DRAIN: begin
                // Leave as soon as the last write is being registered.
                if (wcnt_next == num_vec_reg) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (!start_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg      <= IDLE;
            start_prev_reg <= 1'b0;
            i_base_reg     <= '0;
            o_base_reg     <= '0;
            num_vec_reg    <= '0;
            cnt_reg        <= '0;
            wcnt_reg       <= '0;
            wb_cenb_reg    <= 1'b1;
            wb_addr_reg    <= '0;
            ib_cenb_reg    <= 1'b1;
            ib_addr_reg    <= '0;
            ob_cenb_reg    <= 1'b1;
            ob_addr_reg    <= '0;
            ob_data_reg    <= '0;
            ovf_reg        <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            w_load_reg     <= 1'b0;
            i_valid_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            start_prev_reg <= start_i;
            i_base_reg     <= i_base_next;
            o_base_reg     <= o_base_next;
            num_vec_reg    <= num_vec_next;
            cnt_reg        <= cnt_next;
            wcnt_reg       <= wcnt_next;
            wb_cenb_reg    <= wb_cenb_next;
            wb_addr_reg    <= wb_addr_next;
            ib_cenb_reg    <= ib_cenb_next;
            ib_addr_reg    <= ib_addr_next;
            ob_cenb_reg    <= ob_cenb_next;
            ob_addr_reg    <= ob_addr_next;
            ob_data_reg    <= ob_data_next;
            ovf_reg        <= ovf_next;
            busy_reg       <= in_pass;
            done_reg       <= (state_reg == DONE);
            // Strobes trail the read they qualify by the 1-cycle memory latency.
            w_load_reg     <= (state_reg == LOAD_W);
            i_valid_reg    <= (state_reg == STREAM);
        end
    end

    assign busy_o            = busy_reg;
    assign done_o            = done_reg;
    assign ovf_o             = ovf_reg;
    assign bus.wb_mem_cenb_o = wb_cenb_reg;
    assign bus.wb_mem_wenb_o = 1'b1;
    assign bus.wb_mem_addr_o = wb_addr_reg;
    assign bus.ib_mem_cenb_o = ib_cenb_reg;
    assign bus.ib_mem_wenb_o = 1'b1;
    assign bus.ib_mem_addr_o = ib_addr_reg;
    assign bus.w_load_o      = w_load_reg;
    assign bus.i_valid_o     = i_valid_reg;
    assign bus.ob_mem_cenb_o = ob_cenb_reg;
    assign bus.ob_mem_wenb_o = ob_cenb_reg;
    assign bus.ob_mem_addr_o = ob_addr_reg;
    assign bus.ob_mem_data_o = ob_data_reg;
endmodule
